// File: rtl/irq_pkg.sv
// Shared types and constants for the irq_ctrl interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ISSUE   = 2'd1,
        IRQ_DRAIN   = 2'd2,
        IRQ_SERVICE = 2'd3
    } irq_state_e;

    localparam logic [1:0] IRQ_ADDR_MASK    = 2'd0;
    localparam logic [1:0] IRQ_ADDR_PENDING = 2'd1;
    localparam logic [1:0] IRQ_ADDR_CLR     = 2'd2;
    localparam logic [1:0] IRQ_ADDR_CTRL    = 2'd3;

    localparam int IRQ_GIE_BIT = 0;
    localparam int IRQ_REG_W   = 8;
    localparam int IRQ_ID_W    = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins, with a valid flag.
module irq_prio_enc #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req_i,
    output logic [IDW-1:0] idx_o,
    output logic           valid_o
);

    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        idx_o   = '0;
        valid_o = 1'b0;
        // Scanning downwards lets the lowest requesting index overwrite the rest.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: sync, pending/mask/GIE, priority pick, timed one-hot issue, EOI wait.
// Define IRQ_EDGE_EN for edge-latched pending bits; the default build is level-sensitive.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_IRQ-1:0]   irq_in,
    output logic [NUM_IRQ-1:0]   inj_irq,
    input  logic                 inj_busy,
    input  logic                 eoi,
    input  logic                 reg_we,
    input  logic [1:0]           reg_addr,
    input  logic [IRQ_REG_W-1:0] reg_wdata,
    output logic [IRQ_REG_W-1:0] reg_rdata,
    output logic                 in_service,
    output logic [IRQ_ID_W-1:0]  active_id
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    logic [NUM_IRQ-1:0]  sync1_q, sync2_q;
    logic [NUM_IRQ-1:0]  pending_q, pending_d;
    logic [NUM_IRQ-1:0]  mask_q, mask_d;
    logic                gie_q, gie_d;

    irq_state_e          state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                seen_busy_q, seen_busy_d;
    logic [NUM_IRQ-1:0]  inj_irq_q, inj_irq_d;
    logic                in_service_q, in_service_d;
    logic [IRQ_ID_W-1:0] active_id_q, active_id_d;

    logic [NUM_IRQ-1:0]  eligible;
    logic [IRQ_ID_W-1:0] win_id;
    logic                win_valid;
    logic                issue;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        mask_d = mask_q;
        gie_d  = gie_q;
        if (reg_we) begin
            case (reg_addr)
                IRQ_ADDR_MASK: mask_d = reg_wdata[NUM_IRQ-1:0];
                IRQ_ADDR_CTRL: gie_d  = reg_wdata[IRQ_GIE_BIT];
                default:       ;
            endcase
        end
    end

`ifdef IRQ_EDGE_EN
    logic [NUM_IRQ-1:0] sync3_q;
    logic [NUM_IRQ-1:0] rise, w1c, issue_clr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sync3_q <= '0;
        else        sync3_q <= sync2_q;
    end

    assign rise      = sync2_q & ~sync3_q;
    assign w1c       = (reg_we && reg_addr == IRQ_ADDR_CLR) ? reg_wdata[NUM_IRQ-1:0] : '0;
    assign issue_clr = issue ? (NUM_IRQ'(1) << win_id) : '0;
    // A fresh edge is OR-ed in last so it survives a same-cycle clear.
    assign pending_d = (pending_q & ~(w1c | issue_clr)) | rise;
`else
    assign pending_d = sync2_q;
`endif

    // Arbitration uses registered MASK/GIE, so a same-cycle write cannot affect it.
    assign eligible = gie_q ? (pending_q & mask_q) : '0;

    irq_prio_enc #(
        .N   (NUM_IRQ),
        .IDW (IRQ_ID_W)
    ) u_prio (
        .req_i   (eligible),
        .idx_o   (win_id),
        .valid_o (win_valid)
    );

    assign issue = (state_q == IRQ_IDLE) && win_valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IRQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE:    if (issue) state_d = IRQ_ISSUE;
            IRQ_ISSUE:   if (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1)) state_d = IRQ_DRAIN;
            IRQ_DRAIN:   if (seen_busy_q && !inj_busy) state_d = IRQ_SERVICE;
            IRQ_SERVICE: if (eoi) state_d = IRQ_IDLE;
            default:     state_d = IRQ_IDLE;
        endcase
    end

    always_comb begin
        active_id_d  = issue ? win_id : active_id_q;
        in_service_d = in_service_q;
        if (issue)
            in_service_d = 1'b1;
        else if (state_q == IRQ_SERVICE && eoi)
            in_service_d = 1'b0;
        inj_irq_d   = (state_d == IRQ_ISSUE) ? (NUM_IRQ'(1) << active_id_d) : '0;
        hold_cnt_d  = (state_q == IRQ_ISSUE) ? hold_cnt_q + CNT_W'(1) : '0;
        // Busy may rise while the vector is still held, so watch from ISSUE onwards.
        seen_busy_d = (state_q inside {IRQ_ISSUE, IRQ_DRAIN}) ? (seen_busy_q | inj_busy) : 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_q    <= '0;
            mask_q       <= '0;
            gie_q        <= 1'b0;
            hold_cnt_q   <= '0;
            seen_busy_q  <= 1'b0;
            inj_irq_q    <= '0;
            in_service_q <= 1'b0;
            active_id_q  <= '0;
        end else begin
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            gie_q        <= gie_d;
            hold_cnt_q   <= hold_cnt_d;
            seen_busy_q  <= seen_busy_d;
            inj_irq_q    <= inj_irq_d;
            in_service_q <= in_service_d;
            active_id_q  <= active_id_d;
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            IRQ_ADDR_MASK:    reg_rdata[NUM_IRQ-1:0] = mask_q;
            IRQ_ADDR_PENDING: reg_rdata[NUM_IRQ-1:0] = pending_q;
            IRQ_ADDR_CTRL:    reg_rdata[IRQ_GIE_BIT] = gie_q;
            default:          ;
        endcase
    end

    assign inj_irq    = inj_irq_q;
    assign in_service = in_service_q;
    assign active_id  = active_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: register table plus hand-written interrupt sequences.
module tb_irq_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic [7:0] inj_irq;
    logic       inj_busy = 1'b0;
    logic       eoi = 1'b0;
    logic       reg_we = 1'b0;
    logic [1:0] reg_addr = 2'd0;
    logic [7:0] reg_wdata = 8'h00;
    logic [7:0] reg_rdata;
    logic       in_service;
    logic [2:0] active_id;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef IRQ_EDGE_EN
    localparam logic [7:0] EXP_AFTER_W1C = 8'h00;
`else
    localparam logic [7:0] EXP_AFTER_W1C = 8'h42;
`endif

    irq_ctrl u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .irq_in     (irq_in),
        .inj_irq    (inj_irq),
        .inj_busy   (inj_busy),
        .eoi        (eoi),
        .reg_we     (reg_we),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .in_service (in_service),
        .active_id  (active_id)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       we;
        logic [1:0] waddr;
        logic [7:0] wdata;
        logic [7:0] irq;
        logic [1:0] raddr;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [7:0] data);
        tick();
        reg_we    = 1'b1;
        reg_addr  = addr;
        reg_wdata = data;
        tick();
        reg_we    = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] addr, input logic [7:0] exp);
        reg_addr = addr;
        @(negedge CLK);
        check(name, reg_rdata, exp);
    endtask

    task automatic expect_issue(input string name, input logic [7:0] exp_vec,
                                input logic [2:0] exp_id, output int waited);
        bit seen;
        int held;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            waited++;
            if (inj_irq != 8'h00) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, "_vec"}, inj_irq, exp_vec);
            check({name, "_id"}, active_id, exp_id);
            check({name, "_insvc"}, in_service, 1);
            held = 1;
            for (int i = 0; i < 10; i++) begin
                @(negedge CLK);
                if (inj_irq == exp_vec) held++;
                else break;
            end
            check({name, "_hold"}, held, 3);
            check({name, "_release"}, inj_irq, 0);
        end
    endtask

    // Drops the serviced line, sends a stray EOI, then a busy pulse from the sequencer.
    task automatic drain(input string name, input logic [7:0] drop);
        tick();
        irq_in = irq_in & ~drop;
        eoi    = 1'b1;
        tick();
        eoi      = 1'b0;
        inj_busy = 1'b1;
        tick();
        tick();
        inj_busy = 1'b0;
        repeat (4) tick();
        check({name, "_insvc_held"}, in_service, 1);
    endtask

    task automatic end_service(input string name);
        tick();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        @(negedge CLK);
        check({name, "_eoi_insvc"}, in_service, 0);
        check({name, "_eoi_inj"}, inj_irq, 0);
    endtask

    initial begin
        int w;

        vecs[0] = '{1'b1, 2'd0, 8'hA5, 8'h00, 2'd0, 8'hA5, "mask_rw"};
        vecs[1] = '{1'b1, 2'd3, 8'hFF, 8'h00, 2'd3, 8'h01, "ctrl_gie_only"};
        vecs[2] = '{1'b1, 2'd3, 8'hFE, 8'h00, 2'd3, 8'h00, "ctrl_clear"};
        vecs[3] = '{1'b1, 2'd1, 8'hFF, 8'h00, 2'd1, 8'h00, "pending_ro"};
        vecs[4] = '{1'b0, 2'd0, 8'h00, 8'h42, 2'd1, 8'h42, "pending_lines"};
        vecs[5] = '{1'b1, 2'd2, 8'hFF, 8'h42, 2'd2, 8'h00, "clr_reads_zero"};
        vecs[6] = '{1'b0, 2'd0, 8'h00, 8'h42, 2'd1, EXP_AFTER_W1C, "after_w1c"};
        vecs[7] = '{1'b0, 2'd0, 8'h00, 8'h00, 2'd1, 8'h00, "lines_idle"};
        vecs[8] = '{1'b1, 2'd0, 8'h3C, 8'h00, 2'd0, 8'h3C, "mask_rw2"};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_inj", inj_irq, 0);
        check("rst_insvc", in_service, 0);
        check("rst_id", active_id, 0);
        reg_addr = 2'd0; #1;
        check("rst_mask", reg_rdata, 0);
        reg_addr = 2'd1; #1;
        check("rst_pending", reg_rdata, 0);
        reg_addr = 2'd3; #1;
        check("rst_ctrl", reg_rdata, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Register table (GIE is off whenever lines are active)
        for (int i = 0; i < 9; i++) begin
            irq_in = vecs[i].irq;
            if (vecs[i].we) reg_write(vecs[i].waddr, vecs[i].wdata);
            else tick();
            repeat (4) tick();
            read_check(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end

        // Single request on line 0 with exact latency
        reg_write(2'd0, 8'h01);
        reg_write(2'd3, 8'h01);
        irq_in = 8'h01;
        tick();
        tick();
        irq_in   = 8'h00;
        reg_addr = 2'd1;
        @(posedge CLK);
        @(negedge CLK);
        check("l0_pending", reg_rdata, 8'h01);
        check("l0_not_yet", inj_irq, 0);
        expect_issue("l0", 8'h01, 3'd0, w);
        check("l0_latency", w, 1);
        drain("l0", 8'h01);
        end_service("l0");

        // Two simultaneous requests: lowest index first
        reg_write(2'd0, 8'hFF);
        irq_in = 8'h28;
        expect_issue("pri_a", 8'h08, 3'd3, w);
        drain("pri_a", 8'h08);
        end_service("pri_a");
        expect_issue("pri_b", 8'h20, 3'd5, w);
        check("pri_b_back_to_back", w, 1);
        drain("pri_b", 8'h20);
        end_service("pri_b");

        // Masked request stays pending, then issues once unmasked
        reg_write(2'd0, 8'h00);
        irq_in = 8'h04;
        repeat (6) tick();
        check("masked_no_issue", inj_irq, 0);
        check("masked_no_insvc", in_service, 0);
        read_check("masked_pending", 2'd1, 8'h04);
        reg_write(2'd0, 8'h04);
        expect_issue("unmask", 8'h04, 3'd2, w);
        drain("unmask", 8'h04);
        end_service("unmask");

        // GIE off latches but does not issue
        reg_write(2'd3, 8'h00);
        reg_write(2'd0, 8'hFF);
        irq_in = 8'h40;
        repeat (6) tick();
        check("gie_off_no_issue", inj_irq, 0);
        read_check("gie_off_pending", 2'd1, 8'h40);
        reg_write(2'd3, 8'h01);
        expect_issue("gie_on", 8'h40, 3'd6, w);
        drain("gie_on", 8'h40);
        end_service("gie_on");

        // Request during SERVICE waits for EOI, then issues one cycle later
        irq_in = 8'h80;
        expect_issue("svc", 8'h80, 3'd7, w);
        drain("svc", 8'h80);
        irq_in = irq_in | 8'h02;
        repeat (6) tick();
        check("svc_blocked_inj", inj_irq, 0);
        check("svc_blocked_insvc", in_service, 1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        @(negedge CLK);
        check("svc_idle_insvc", in_service, 0);
        check("svc_idle_inj", inj_irq, 0);
        @(negedge CLK);
        check("svc_next_inj", inj_irq, 8'h02);
        check("svc_next_id", active_id, 1);
        drain("svc_next", 8'h02);
        end_service("svc_next");

        // Same-cycle set and write-1-to-clear
        reg_write(2'd3, 8'h00);
`ifdef IRQ_EDGE_EN
        irq_in = 8'h10;
        repeat (5) tick();
        irq_in = 8'h00;
        repeat (4) tick();
        read_check("edge_latched", 2'd1, 8'h10);
        tick();
        irq_in = 8'h10;
        tick();
        tick();
        reg_we    = 1'b1;
        reg_addr  = 2'd2;
        reg_wdata = 8'h10;
        tick();
        reg_we = 1'b0;
        read_check("set_wins", 2'd1, 8'h10);
        reg_write(2'd2, 8'h10);
        read_check("w1c_alone", 2'd1, 8'h00);
        irq_in = 8'h00;
`else
        irq_in = 8'h10;
        repeat (5) tick();
        reg_write(2'd2, 8'h10);
        read_check("w1c_no_effect", 2'd1, 8'h10);
        irq_in = 8'h00;
        repeat (5) tick();
        read_check("level_mirror", 2'd1, 8'h00);
`endif

        // Asynchronous reset while the vector is being held
        reg_write(2'd0, 8'hFF);
        reg_write(2'd3, 8'h01);
        reg_addr = 2'd0;
        irq_in   = 8'h02;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge CLK);
                if (inj_irq != 8'h00) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rst_mid_seen", 32'(seen), 32'd1);
        end
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_mid_inj", inj_irq, 0);
        check("rst_mid_insvc", in_service, 0);
        check("rst_mid_id", active_id, 0);
        check("rst_mid_mask", reg_rdata, 0);
        irq_in = 8'h00;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        check("rst_after_idle", inj_irq, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller sitting between the eight peripheral interrupt lines and the CPU's instruction-injecting interrupt sequencer. It synchronises and latches requests, applies a software-programmable mask and global enable, and picks one request by fixed priority. It then drives that request to the sequencer as a one-hot vector for exactly the window the sequencer needs. Once the handler runs, it holds off further requests until the CPU signals end-of-interrupt (EOI).

## Interface
Parameters:
- `NUM_IRQ`, 8: interrupt line count; must match the sequencer input width.
- `HOLD_CYCLES`, 3: cycles the one-hot vector is held, covering the sequencer's sample, save and vector-decode states.

Ports:
- `CLK`: in, 1. Single clock.
- `RST_N`: in, 1. Asynchronous, active-low reset.
- `irq_in`: in, `NUM_IRQ`. Raw peripheral lines; may be asynchronous to `CLK`.
- `inj_irq`: out, `NUM_IRQ`. One-hot request to the sequencer's interrupt input.
- `inj_busy`: in, 1. Sequencer's interrupt-in-progress flag.
- `eoi`: in, 1. One-cycle pulse from the CPU on return-from-interrupt.
- `reg_we`: in, 1. Register write strobe.
- `reg_addr`: in, 2. Register select.
- `reg_wdata`: in, 8. Write data.
- `reg_rdata`: out, 8. Combinational read data.
- `in_service`: out, 1. High from issue until EOI is accepted.
- `active_id`: out, 3. Index of the interrupt being serviced.

## Operation
- Each `irq_in` bit passes through a 2-flop synchroniser into the pending logic.
- Register map:
  - addr 0: `MASK`, read/write. 1 enables the line.
  - addr 1: `PENDING`, read-only.
  - addr 2: write-1-to-clear `PENDING`; reads return 0.
  - addr 3: `CTRL`. Bit 0 is `GIE`; bits 7:1 read as 0.
- Eligible set is `PENDING & MASK`, considered only when `GIE` = 1. Lowest index wins (bit 0 is the highest priority).
- FSM states:
  - `IDLE`: if the eligible set is non-empty, latch the winner into `active_id`, clear its pending bit, set `in_service`, drive `inj_irq` one-hot and go to `ISSUE`.
  - `ISSUE`: hold `inj_irq` for `HOLD_CYCLES` cycles in total, counting the entry cycle. Then drive `inj_irq` to 0 and go to `DRAIN`.
  - `DRAIN`: wait until `inj_busy` has been seen high and has then returned low, then go to `SERVICE`.
  - `SERVICE`: on `eoi`, clear `in_service` and go to `IDLE`.
- Boundary rules:
  - Pending-set and write-1-to-clear on the same bit in the same cycle: set wins.
  - Changing `MASK` or `GIE` does not abort an interrupt that has already issued.
  - `eoi` outside `SERVICE` is ignored.
  - `GIE` = 0 blocks only new issues; pending bits still latch.
  - Reset mid-operation returns the FSM to `IDLE` immediately; no partial vector is left on `inj_irq`.
- Reset values: `inj_irq`=0, `in_service`=0, `active_id`=0, `MASK`=0, `PENDING`=0, `GIE`=0, FSM=`IDLE`.

## Timing
- Latency: synchronised edge to pending set is 3 cycles. Pending set to `inj_irq` non-zero is 1 cycle, when in `IDLE` and eligible.
- `inj_irq` is registered and stable for exactly `HOLD_CYCLES` cycles, then zero. When the sequencer returns to its idle state, it therefore sees no request.
- Minimum spacing between two issues is `HOLD_CYCLES` + 1 + EOI wait + 1 cycles.
- A register write takes effect on the next cycle. A write in the same cycle as an `IDLE` arbitration does not affect that arbitration.

## Configuration
- `IRQ_EDGE_EN`:
  - Defined: a pending bit sets on a synchronised rising edge of its line and stays set until issued or cleared by software.
  - Undefined: level-sensitive. `PENDING` mirrors the synchronised lines, there is no latching, and the write-1-to-clear register has no effect. The issue itself does not clear the source; the handler must deassert the line before EOI.

## Structure
- Shared package `irq_pkg`: FSM state enum, register address constants (`IRQ_ADDR_MASK`/`PENDING`/`CLR`/`CTRL`), `GIE` bit index.
- One sub-module, `irq_prio_enc`: combinational lowest-index-first encoder producing the index and a valid flag. The one-hot vector is derived from the index.

## Test plan
- Reset with lines idle, then set `MASK`=0x01 and `GIE`=1; pulse `irq_in[0]` → `inj_irq`=0x01 for 3 cycles, `active_id`=0. After the `inj_busy` pulse and an `eoi`, `in_service` returns to 0.
- `irq_in`=0x28 together, `MASK`=0xFF → first issue `inj_irq`=0x08; after EOI the second issue is `inj_irq`=0x20.
- `MASK`=0x00 and pulse `irq_in[2]` → no issue and `PENDING`=0x04. Writing `MASK`=0x04 → issue `inj_irq`=0x04.
- During `SERVICE`, pulse `irq_in[1]` → no issue until `eoi`; issue follows 1 cycle after returning to `IDLE`.
- With `PENDING`=0x10, write 0x10 to addr 2 while `irq_in[4]` edge-sets in the same cycle → `PENDING` stays 0x10 (`IRQ_EDGE_EN` defined).
- Assert `RST_N`=0 during `ISSUE` → `inj_irq`=0, `in_service`=0, `MASK`=0 asynchronously.
